// File: rtl/mips_pkg.sv
// Shared MIPS datapath definitions: default widths, control bundle and
// the EX/MEM stage state encoding.
package mips_pkg;

  localparam int DATA_W_DEF     = 32;
  localparam int REG_ADDR_W_DEF = 5;

  typedef struct packed {
    logic mem_read;
    logic mem_write;
    logic reg_write;
    logic mem_to_reg;
  } ctrl_t;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } stage_state_t;

endpackage

// File: rtl/branch_resolve.sv
// Combinational beq/bne decision and branch target from the ALU zero flag.
module branch_resolve #(
  parameter int DATA_W = 32
) (
  input  logic              is_beq,
  input  logic              is_bne,
  input  logic              alu_zero,
  input  logic [DATA_W-1:0] pc_plus4,
  input  logic [DATA_W-1:0] imm_sext,
  output logic              taken,
  output logic [DATA_W-1:0] target
);

  assign taken  = (is_beq & alu_zero) | (is_bne & ~alu_zero);
  // Word offset; the add wraps naturally at DATA_W bits.
  assign target = pc_plus4 + (imm_sext << 2);

endmodule

// File: rtl/ex_mem_stage.sv
// EX/MEM pipeline register with a 2-entry skid buffer and registered
// branch redirect. in_ready depends only on the state register.
//
// state | meaning
// EMPTY | no entries held
// ONE   | head entry valid, skid empty
// TWO   | head and skid valid, EX is back-pressured
module ex_mem_stage
  import mips_pkg::*;
#(
  parameter int DATA_W     = DATA_W_DEF,
  parameter int REG_ADDR_W = REG_ADDR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_W-1:0]     alu_result,
  input  logic                  alu_zero,
  input  logic [DATA_W-1:0]     rt_data,
  input  logic [REG_ADDR_W-1:0] dest_reg,
  input  logic [DATA_W-1:0]     pc_plus4,
  input  logic [DATA_W-1:0]     imm_sext,
  input  logic                  is_beq,
  input  logic                  is_bne,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic                  reg_write,
  input  logic                  mem_to_reg,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [DATA_W-1:0]     out_alu_result,
  output logic [DATA_W-1:0]     out_store_data,
  output logic [REG_ADDR_W-1:0] out_dest_reg,
  output logic                  out_mem_read,
  output logic                  out_mem_write,
  output logic                  out_reg_write,
  output logic                  out_mem_to_reg,
  output logic                  branch_taken,
  output logic [DATA_W-1:0]     branch_target
);

  typedef struct packed {
    logic [DATA_W-1:0]     alu;
    logic [DATA_W-1:0]     store;
    logic [REG_ADDR_W-1:0] dest;
    ctrl_t                 ctrl;
  } entry_t;

  stage_state_t state_q, state_d;
  entry_t       head_q, skid_q, in_entry;
  logic         accept, pop;
  logic         load_head_in, load_head_skid, load_skid;
  logic         br_taken;
  logic [DATA_W-1:0] br_target;
  logic         taken_q;
  logic [DATA_W-1:0] target_q;

  branch_resolve #(.DATA_W(DATA_W)) u_branch (
    .is_beq   (is_beq),
    .is_bne   (is_bne),
    .alu_zero (alu_zero),
    .pc_plus4 (pc_plus4),
    .imm_sext (imm_sext),
    .taken    (br_taken),
    .target   (br_target)
  );

  assign in_entry.alu   = alu_result;
  assign in_entry.store = rt_data;
  assign in_entry.dest  = dest_reg;
  assign in_entry.ctrl  = '{mem_read, mem_write, reg_write, mem_to_reg};

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign accept    = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  always_comb begin
    state_d        = state_q;
    load_head_in   = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    if (flush) begin
      state_d = EMPTY;
    end else begin
      case (state_q)
        EMPTY: if (accept) begin
          state_d      = ONE;
          load_head_in = 1'b1;
        end
        ONE: begin
          if (accept && !pop) begin
            state_d   = TWO;
            load_skid = 1'b1;
          end else if (accept && pop) begin
            load_head_in = 1'b1;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_d        = ONE;
          load_head_skid = 1'b1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= EMPTY;
      head_q   <= '0;
      skid_q   <= '0;
      taken_q  <= 1'b0;
      target_q <= '0;
    end else begin
      state_q <= state_d;
      if (load_head_in)   head_q <= in_entry;
      if (load_head_skid) head_q <= skid_q;
      if (load_skid)      skid_q <= in_entry;
      // A flushed accept must not redirect fetch.
      taken_q <= accept & br_taken & ~flush;
      if (accept && br_taken && !flush) target_q <= br_target;
    end
  end

  assign out_alu_result = head_q.alu;
  assign out_store_data = head_q.store;
  assign out_dest_reg   = head_q.dest;
  assign out_mem_read   = head_q.ctrl.mem_read;
  assign out_mem_write  = head_q.ctrl.mem_write;
  assign out_reg_write  = head_q.ctrl.reg_write;
  assign out_mem_to_reg = head_q.ctrl.mem_to_reg;
  assign branch_taken   = taken_q;
  assign branch_target  = target_q;

endmodule

// File: doc/ex_mem_stage.md
Name: ex_mem_stage

Overview:
- EX/MEM pipeline stage directly downstream of the 32-bit ALU in the MIPS datapath.
- Captures the ALU result, the zero flag and the forwarded control/data, and resolves beq/bne using the zero flag.
- Presents one registered entry to the memory stage with a valid/ready handshake.
- Contains a 2-entry skid buffer, so memory-stage stalls never create a combinational ready path back into EX.

Parameters:
- DATA_W, 32, datapath width (ALU result, store data, PC).
- REG_ADDR_W, 5, register-file address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- flush  in  1  discard all held entries (hazard/exception kill)
- in_valid  in  1  EX presents a valid instruction
- in_ready  out  1  stage can accept this cycle
- alu_result  in  DATA_W  ALU result output
- alu_zero  in  1  ALU zero flag
- rt_data  in  DATA_W  store data
- dest_reg  in  REG_ADDR_W  write-back register
- pc_plus4  in  DATA_W  PC+4 of the instruction
- imm_sext  in  DATA_W  sign-extended branch immediate
- is_beq, is_bne, mem_read, mem_write, reg_write, mem_to_reg  in  1 each  decoded control
- out_valid  out  1  head entry valid
- out_ready  in  1  MEM stage consumes head
- out_alu_result, out_store_data  out  DATA_W  head entry fields
- out_dest_reg  out  REG_ADDR_W
- out_mem_read, out_mem_write, out_reg_write, out_mem_to_reg  out  1 each
- branch_taken  out  1  one-cycle redirect pulse
- branch_target  out  DATA_W  redirect address, valid while branch_taken=1

Behaviour:
- Reset (rst_n=0, async): both entries invalid; all outputs 0; in_ready=1 after deassertion; FSM=EMPTY.
- Handshake:
  - Accept when in_valid & in_ready.
  - Pop when out_valid & out_ready.
  - Payload must stay stable while out_valid=1 and out_ready=0.
- in_ready = ~skid_valid. It is registered and never depends on out_ready in the same cycle.
- FSM states:
  - EMPTY: accept -> ONE (entry into head).
  - ONE: accept & ~pop -> TWO (entry into skid). pop & ~accept -> EMPTY. Accept & pop -> ONE (new entry replaces head).
  - TWO: in_ready=0. pop -> ONE (skid moves to head).
- Latency: an accept at cycle N is visible on out_* at N+1 when the stage was EMPTY. FIFO order is always preserved.
- Branch resolution at accept time:
  - taken = (is_beq & alu_zero) | (is_bne & ~alu_zero).
  - target = pc_plus4 + (imm_sext << 2), truncated to DATA_W (wraps mod 2^32).
  - branch_taken is registered: it pulses high for exactly one cycle (N+1), with branch_target held the same cycle.
  - Otherwise branch_taken=0 and branch_target holds its previous value.
- Both is_beq and is_bne set is illegal; taken = alu_zero | ~alu_zero = 1. The bench must not drive this.
- Branch entries still enter the buffer (reg_write=0, mem_* = 0 expected from decode). They are not dropped.
- flush priority:
  - flush=1 at an edge: both entries invalidated, FSM -> EMPTY, next-cycle branch_taken forced 0.
  - An accept in the same cycle is discarded.
  - A pop in the same cycle is still considered done by MEM (stage takes no action).
- Flush in TWO: in_ready returns to 1 the following cycle.
- Reset mid-operation: immediate clear regardless of handshake state.

Decomposition:
- Shared package mips_pkg: DATA_W/REG_ADDR_W defaults, ctrl bundle field order (mem_read, mem_write, reg_write, mem_to_reg), FSM encoding EMPTY=2'd0, ONE=2'd1, TWO=2'd2.
- One natural sub-module: branch_resolve, a combinational taken/target calculation instantiated once.

Test Plan:
- Reset then single beq with alu_zero=1, pc_plus4=0x00000010, imm_sext=0x00000003, out_ready=1 -> cycle+1: out_valid=1, branch_taken=1 for one cycle, branch_target=0x0000001C.
- bne with alu_zero=0, pc_plus4=0x00000004, imm_sext=0xFFFFFFFF -> branch_taken=1, branch_target=0x00000000. Same with alu_zero=1 -> branch_taken=0.
- Stall fill: out_ready=0, push results 0xA, 0xB -> in_ready=0 after second accept, out_alu_result stays 0xA. Raise out_ready -> 0xA then 0xB pop in order, in_ready back to 1.
- Simultaneous accept+pop in ONE with back-to-back stream 1..100, out_ready=1 -> all 100 delivered in order, no bubbles after the first cycle.
- flush while TWO, with in_valid=1 the same cycle -> next cycle out_valid=0, in_ready=1, branch_taken=0, flushed data never appears.
- rst_n pulsed low mid-stall with a taken branch pending -> all outputs 0 immediately, no branch_taken pulse after release.
